siso_arb_ctrl: RTL and testbench

SISO_ARB_CTRL -- requirements
Module: siso_arb_ctrl

---
 rtl/siso_arb_ctrl.sv | 115 +++++++++++
 tb/tb_siso_arb_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/siso_arb_ctrl.sv
// Two-channel round-robin arbiter that sends the granted word MSB-first through
// a DEPTH-stage serial line and reassembles it at the far end for a ready/valid consumer.
module siso_arb_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             busy,
  output logic             ser_mon
);

  localparam int RUN_LEN = WIDTH + DEPTH;
  localparam int CW      = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] W_C    = CW'(WIDTH);
  localparam logic [CW-1:0] D_C    = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C = CW'(RUN_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             id_q, id_d;
  logic [DEPTH-1:0] line_q, line_d;
  logic [WIDTH-1:0] col_q, col_d;
  logic             ser_in;
  logic             grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      word_q  <= '0;
      id_q    <= 1'b0;
      line_q  <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      id_q    <= id_d;
      line_q  <= line_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    id_d    = id_q;
    col_d   = col_q;
    ser_in  = 1'b0;
    grant1  = req1 & (~req0 | rr_q);

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = RUN;
          id_d    = grant1;
          word_d  = grant1 ? data1 : data0;
          rr_d    = ~grant1;
          cnt_d   = '0;
          col_d   = '0;
        end
      end
      RUN: begin
        // word_q is consumed MSB-first; the collector rebuilds it
        if (cnt_q < W_C) begin
          ser_in = word_q[WIDTH-1];
          word_d = word_q << 1;
        end
        if (cnt_q >= D_C)
          col_d = (col_q << 1) | WIDTH'(line_q[DEPTH-1]);
        if (cnt_q == LAST_C)
          state_d = DONE;
        else
          cnt_d = cnt_q + 1'b1;
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    line_d[0] = ser_in;
    for (int i = 1; i < DEPTH; i++)
      line_d[i] = line_q[i-1];
  end

  assign ack0      = (state_q == RUN) && (cnt_q == '0) && !id_q;
  assign ack1      = (state_q == RUN) && (cnt_q == '0) &&  id_q;
  assign out_valid = (state_q == DONE);
  assign out_data  = (state_q == DONE) ? col_q : '0;
  assign out_id    = (state_q == DONE) && id_q;
  assign busy      = (state_q != IDLE);
  assign ser_mon   = line_q[DEPTH-1];

endmodule

// File: tb/tb_siso_arb_ctrl.sv
// Directed bench for siso_arb_ctrl: reset, single transfer, serial timing,
// contention, backpressure, mid-RUN reset and round-robin fairness.
module tb_siso_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] data0 = '0, data1 = '0;
  logic       ack0, ack1;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic       out_id;
  logic       busy;
  logic       ser_mon;

  int n_chk  = 0;
  int n_fail = 0;

  siso_arb_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id),
    .busy(busy), .ser_mon(ser_mon)
  );

  always #5 clk = ~clk;

  // Waits for the grant, follows RUN cycle by cycle, holds DONE for bp cycles, then handshakes.
  task automatic xfer(input logic exp_id, input logic [3:0] exp_data,
                      input bit chk_ser, input int bp, input bit drop);
    int t = 0;
    logic [1:0] exp_ack;
    exp_ack = exp_id ? 2'b10 : 2'b01;
    @(negedge clk);
    while (!(ack0 || ack1) && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if ({ack1, ack0} !== exp_ack) begin
      n_fail++;
      $display("FAIL grant_ack: acks=%b required=%b", {ack1, ack0}, exp_ack);
      return;
    end
    if (drop) begin
      if (exp_id) req1 = 1'b0; else req0 = 1'b0;
    end
    if (chk_ser) begin
      n_chk++;
      if (ser_mon !== 1'b0) begin
        n_fail++;
        $display("FAIL ser_mon_cnt0: got=%b required=0", ser_mon);
      end
    end
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== (n == 8) || ack0 !== 1'b0 || ack1 !== 1'b0) begin
        n_fail++;
        $display("FAIL run_timing n=%0d: out_valid=%b acks=%b required valid=%b acks=00",
                 n, out_valid, {ack1, ack0}, (n == 8));
      end
      if (chk_ser) begin
        n_chk++;
        if (ser_mon !== (n == 4)) begin
          n_fail++;
          $display("FAIL ser_mon n=%0d: got=%b required=%b", n, ser_mon, (n == 4));
        end
      end
    end
    n_chk++;
    if (out_data !== exp_data || out_id !== exp_id) begin
      n_fail++;
      $display("FAIL done_word: data=%h id=%b required data=%h id=%b",
               out_data, out_id, exp_data, exp_id);
    end
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== exp_data || out_id !== exp_id) begin
        n_fail++;
        $display("FAIL backpressure b=%0d: valid=%b data=%h id=%b required 1 %h %b",
                 b, out_valid, out_data, out_id, exp_data, exp_id);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_bubble: valid=%b busy=%b acks=%b required 0 0 00",
               out_valid, busy, {ack1, ack0});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_chk++;
    if ({ack0, ack1, out_valid, out_data, out_id, busy, ser_mon} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got=%b required=0", {ack0, ack1, out_valid, out_data, out_id, busy, ser_mon});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b valid=%b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_single();
    data0 = 4'b1011;
    req0  = 1'b1;
    xfer(1'b0, 4'b1011, 1'b0, 0, 1'b1);
  endtask

  task automatic test_serial_timing();
    data1 = 4'b1000;
    req1  = 1'b1;
    xfer(1'b1, 4'b1000, 1'b1, 0, 1'b1);
  endtask

  task automatic test_contention();
    test_reset();
    data0 = 4'h3;
    data1 = 4'hC;
    req0  = 1'b1;
    req1  = 1'b1;
    xfer(1'b0, 4'h3, 1'b0, 0, 1'b1);
    xfer(1'b1, 4'hC, 1'b0, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    data0 = 4'h6;
    req0  = 1'b1;
    xfer(1'b0, 4'h6, 1'b0, 5, 1'b1);
  endtask

  task automatic test_reset_mid_run();
    int t = 0;
    data1 = 4'h5;
    req1  = 1'b1;
    @(negedge clk);
    while (!ack1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (ack1 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_grant: ack1=%b required=1", ack1);
    end
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({ack0, ack1, out_valid, out_data, out_id, busy, ser_mon} !== 10'b0) begin
      n_fail++;
      $display("FAIL midrun_reset_outputs: got=%b required=0", {ack0, ack1, out_valid, out_data, out_id, busy, ser_mon});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
        n_fail++;
        $display("FAIL midrun_abort k=%0d: valid=%b busy=%b acks=%b required 0 0 00",
                 k, out_valid, busy, {ack1, ack0});
      end
    end
    data1 = 4'hA;
    req1  = 1'b1;
    xfer(1'b1, 4'hA, 1'b0, 0, 1'b1);
  endtask

  task automatic test_fairness();
    test_reset();
    data0 = 4'h9;
    data1 = 4'h4;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int i = 0; i < 6; i++)
      xfer(i[0], i[0] ? 4'h4 : 4'h9, 1'b0, 0, 1'b0);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_serial_timing();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    test_fairness();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
